// File: rtl/transmitter_buffer_pkg.sv
// transmitter_buffer_pkg
// Shared constants and types for the BPSK transmit framing buffer.
//   PACKET_WIDTH          : packet size in bytes
//   PREAMBLE_LENGTH       : preamble length in bits
//   PREAMBLE              : preamble pattern, sent MSB first
//   IDX_W                 : width of one original-position index
//   PAYLOAD_BITS          : sorted bytes plus index field
//   PACKET_WIDTH_OVERHEAD : total bits in one frame (preamble + payload)
//   tx_state_t            : transmit FSM states
package transmitter_buffer_pkg;

  localparam int PACKET_WIDTH    = 4;
  localparam int PREAMBLE_LENGTH = 8;
  localparam logic [PREAMBLE_LENGTH-1:0] PREAMBLE = 8'hAB;

  localparam int IDX_W                 = $clog2(PACKET_WIDTH);
  localparam int PAYLOAD_BITS          = PACKET_WIDTH * 8 + PACKET_WIDTH * IDX_W;
  localparam int PACKET_WIDTH_OVERHEAD = PREAMBLE_LENGTH + PAYLOAD_BITS;

  // Bit counter covers the longer of the two serial sections; it never wraps.
  localparam int CNT_W = $clog2((PAYLOAD_BITS > PREAMBLE_LENGTH) ? PAYLOAD_BITS : PREAMBLE_LENGTH);
  // Pass counter of the sorter must reach PACKET_WIDTH itself.
  localparam int PASS_W = $clog2(PACKET_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SORT,
    ST_PREAMBLE,
    ST_PAYLOAD
  } tx_state_t;

endpackage

// File: rtl/transmitter_buffer_sort.sv
// transmitter_buffer_sort
// Stable odd-even transposition byte sorter; counterpart of the receiver's
// unsort. Each slot carries the original byte index along with the byte.
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   start     in   load data_in into the slots and begin sorting
//   data_in   in   PACKET_WIDTH bytes, byte k = bits [8k+7:8k]
//   data_out  out  sorted bytes, slot 0 (smallest) in bits [7:0]
//   index_out out  original index of slot s in bits [IDX_W*s +: IDX_W]
//   done      out  one-cycle pulse PACKET_WIDTH+1 cycles after start
module transmitter_buffer_sort
  import transmitter_buffer_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [PACKET_WIDTH*8-1:0]     data_in,
  output logic [PACKET_WIDTH*8-1:0]     data_out,
  output logic [PACKET_WIDTH*IDX_W-1:0] index_out,
  output logic                          done
);

  logic [7:0]       bytes_q [PACKET_WIDTH];
  logic [IDX_W-1:0] idx_q   [PACKET_WIDTH];
  logic [7:0]       bytes_d [PACKET_WIDTH];
  logic [IDX_W-1:0] idx_d   [PACKET_WIDTH];
  logic [PASS_W-1:0] pass_q;
  logic              busy_q;

  // One transposition pass: even passes compare pairs (0,1),(2,3)...,
  // odd passes compare (1,2),(3,4)... The pairs are disjoint, so reading
  // only the current slots is safe.
  // NOTE: every comb output gets its default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    bytes_d = bytes_q;
    idx_d   = idx_q;
    for (int s = 0; s < PACKET_WIDTH - 1; s++) begin
      // Strict compare keeps equal bytes in their original order.
      if (((s % 2) == int'(pass_q[0])) && (bytes_q[s] > bytes_q[s+1])) begin
        bytes_d[s]   = bytes_q[s+1];
        bytes_d[s+1] = bytes_q[s];
        idx_d[s]     = idx_q[s+1];
        idx_d[s+1]   = idx_q[s];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the slot array is small and is reset with everything else so
      // data_out is never X; larger storage would be left unreset.
      for (int s = 0; s < PACKET_WIDTH; s++) begin
        bytes_q[s] <= '0;
        idx_q[s]   <= '0;
      end
      pass_q <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        for (int s = 0; s < PACKET_WIDTH; s++) begin
          bytes_q[s] <= data_in[8*s +: 8];
          idx_q[s]   <= IDX_W'(s);
        end
        pass_q <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (pass_q == PASS_W'(PACKET_WIDTH)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end else begin
          bytes_q <= bytes_d;
          idx_q   <= idx_d;
          pass_q  <= pass_q + PASS_W'(1);
        end
      end
    end
  end

  for (genvar s = 0; s < PACKET_WIDTH; s++) begin : g_out
    assign data_out[8*s +: 8]          = bytes_q[s];
    assign index_out[IDX_W*s +: IDX_W] = idx_q[s];
  end

endmodule

// File: rtl/transmitter_buffer.sv
// transmitter_buffer
// Transmit framing buffer: accepts a packet, byte-sorts it (recording the
// original positions), then serializes preamble, sorted bytes and index
// field one bit per modulator strobe.
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   sys_packet  in   packet to send, byte k = bits [8k+7:8k]
//   load        in   packet strobe, accepted only while ready=1
//   ready       out  high in IDLE only
//   bit_tick    in   modulator strobe consuming the presented bit
//   data_stream out  bit presented to the modulator (0 when not active)
//   tx_active   out  high from first preamble bit through last payload bit
//   done        out  one-cycle pulse when the frame is complete
module transmitter_buffer
  import transmitter_buffer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [PACKET_WIDTH*8-1:0] sys_packet,
  input  logic                      load,
  output logic                      ready,
  input  logic                      bit_tick,
  output logic                      data_stream,
  output logic                      tx_active,
  output logic                      done
);

  localparam int PRE_IDX_W = (PREAMBLE_LENGTH > 1) ? $clog2(PREAMBLE_LENGTH) : 1;
  localparam int PAY_IDX_W = $clog2(PAYLOAD_BITS);

  tx_state_t state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PAYLOAD_BITS-1:0] payload_q;

  logic                          sort_start;
  logic                          sort_done;
  logic [PACKET_WIDTH*8-1:0]     sorted_data;
  logic [PACKET_WIDTH*IDX_W-1:0] index_field;
  logic                          frame_load;

  logic ready_d, tx_active_d, data_d, done_d;

  transmitter_buffer_sort u_sort (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (sort_start),
    .data_in   (sys_packet),
    .data_out  (sorted_data),
    .index_out (index_field),
    .done      (sort_done)
  );

  // Next state, next counter and the next value of every registered output.
  // Outputs are derived from the *next* state/counter so that the bit that
  // becomes current at an edge is the one driven right after that edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    sort_start = 1'b0;
    frame_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          sort_start = 1'b1;
          state_d    = ST_SORT;
        end
      end
      ST_SORT: begin
        if (sort_done) begin
          frame_load = 1'b1;
          cnt_d      = '0;
          state_d    = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (bit_tick) begin
          if (cnt_q == CNT_W'(PREAMBLE_LENGTH - 1)) begin
            cnt_d   = '0;
            state_d = ST_PAYLOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PAYLOAD: begin
        if (bit_tick) begin
          if (cnt_q == CNT_W'(PAYLOAD_BITS - 1)) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    ready_d     = (state_d == ST_IDLE);
    tx_active_d = (state_d == ST_PREAMBLE) || (state_d == ST_PAYLOAD);
    data_d      = 1'b0;
    if (state_d == ST_PREAMBLE) begin
      data_d = PREAMBLE[PRE_IDX_W'(PREAMBLE_LENGTH - 1 - int'(cnt_d))];
    end else if (state_d == ST_PAYLOAD) begin
      // The frame register is loaded on entry to PREAMBLE, so it is stable
      // by the time PAYLOAD reads it.
      data_d = payload_q[PAY_IDX_W'(cnt_d)];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      payload_q   <= '0;
      ready       <= 1'b1;
      tx_active   <= 1'b0;
      data_stream <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready       <= ready_d;
      tx_active   <= tx_active_d;
      data_stream <= data_d;
      done        <= done_d;
      if (frame_load) begin
        payload_q <= {index_field, sorted_data};
      end
    end
  end

endmodule

// File: tb/tb_transmitter_buffer.sv
// tb_transmitter_buffer
// Self-checking bench for transmitter_buffer. Expected frames come from a
// rank-based stable sort model; a receive-side unsort model restores packets.
module tb_transmitter_buffer;
  import transmitter_buffer_pkg::*;

  localparam int PB = PACKET_WIDTH * 8;
  localparam int FB = PACKET_WIDTH_OVERHEAD;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [PB-1:0] sys_packet;
  logic          load;
  logic          ready;
  logic          bit_tick;
  logic          data_stream;
  logic          tx_active;
  logic          done;

  int n_total = 0;
  int n_bad   = 0;

  transmitter_buffer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sys_packet  (sys_packet),
    .load        (load),
    .ready       (ready),
    .bit_tick    (bit_tick),
    .data_stream (data_stream),
    .tx_active   (tx_active),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Frame in transmission order: f[0] is the first bit sent.
  function automatic logic [FB-1:0] model_frame(input logic [PB-1:0] pkt);
    logic [7:0]                 b   [PACKET_WIDTH];
    logic [7:0]                 srt [PACKET_WIDTH];
    int                         orig[PACKET_WIDTH];
    logic [PREAMBLE_LENGTH-1:0] pre;
    logic [FB-1:0]              f;
    int                         rank;
    int                         pos;
    pre = PREAMBLE;
    for (int i = 0; i < PACKET_WIDTH; i++) b[i] = pkt[8*i +: 8];
    // Stable rank: smaller bytes, plus equal bytes that came earlier.
    for (int i = 0; i < PACKET_WIDTH; i++) begin
      rank = 0;
      for (int j = 0; j < PACKET_WIDTH; j++)
        if ((b[j] < b[i]) || ((b[j] == b[i]) && (j < i))) rank++;
      srt[rank]  = b[i];
      orig[rank] = i;
    end
    f   = '0;
    pos = 0;
    for (int k = 0; k < PREAMBLE_LENGTH; k++) begin
      f[pos] = pre[PREAMBLE_LENGTH-1-k];
      pos++;
    end
    for (int s = 0; s < PACKET_WIDTH; s++)
      for (int k = 0; k < 8; k++) begin
        f[pos] = srt[s][k];
        pos++;
      end
    for (int s = 0; s < PACKET_WIDTH; s++)
      for (int k = 0; k < IDX_W; k++) begin
        f[pos] = orig[s][k];
        pos++;
      end
    return f;
  endfunction

  // Receive-side restore: put each sorted byte back at its recorded index.
  function automatic logic [PB-1:0] unsort(input logic [FB-1:0] f);
    logic [PB-1:0] out;
    int            idx;
    out = '0;
    for (int s = 0; s < PACKET_WIDTH; s++) begin
      idx = int'(f[PREAMBLE_LENGTH + PB + IDX_W*s +: IDX_W]);
      out[8*idx +: 8] = f[PREAMBLE_LENGTH + 8*s +: 8];
    end
    return out;
  endfunction

  // Sends one packet and captures the serial frame. Optional junk loads are
  // pulsed during SORT and/or together with the tick of bit junk_bit.
  task automatic run_frame(input logic [PB-1:0] pkt, input bit b2b,
                           input bit junk_sort, input int junk_bit,
                           output logic [FB-1:0] cap);
    int c;
    int gap;
    cap = '0;
    c = 0;
    while ((ready !== 1'b1) && (c < 200)) begin
      @(negedge clk);
      c++;
    end
    n_total++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_wait: got %b want 1", ready);
    end
    sys_packet = pkt;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
    sys_packet = PB'($urandom);
    n_total++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_drop: got %b want 0", ready);
    end
    c = 1;
    while ((tx_active !== 1'b1) && (c < 20)) begin
      load = (junk_sort && (c == 2));
      @(negedge clk);
      c++;
    end
    load = 1'b0;
    n_total++;
    if (c != PACKET_WIDTH + 3) begin
      n_bad++;
      $display("FAIL start_latency: got %0d want %0d", c, PACKET_WIDTH + 3);
    end
    for (int i = 0; i < FB; i++) begin
      if (!b2b) begin
        gap      = $urandom_range(0, 2);
        bit_tick = 1'b0;
        repeat (gap) @(negedge clk);
      end
      cap[i] = data_stream;
      n_total++;
      if ({tx_active, done} !== 2'b10) begin
        n_bad++;
        $display("FAIL in_frame bit %0d: tx_active,done got %b want 10", i, {tx_active, done});
      end
      bit_tick = 1'b1;
      if (i == junk_bit) load = 1'b1;
      @(negedge clk);
      load = 1'b0;
    end
    bit_tick = 1'b0;
    n_total++;
    if ({done, tx_active, ready, data_stream} !== 4'b1010) begin
      n_bad++;
      $display("FAIL frame_end: done,tx_active,ready,data got %b want 1010",
               {done, tx_active, ready, data_stream});
    end
    @(negedge clk);
    n_total++;
    if ({done, tx_active, ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL done_pulse: done,tx_active,ready got %b want 001", {done, tx_active, ready});
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    load       = 1'b0;
    bit_tick   = 1'b0;
    sys_packet = '0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({ready, tx_active, done, data_stream} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_in: got %b want 1000", {ready, tx_active, done, data_stream});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({ready, tx_active, done, data_stream} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_out: got %b want 1000", {ready, tx_active, done, data_stream});
    end
  endtask

  task automatic test_sorted();
    logic [FB-1:0] cap;
    run_frame(32'h44332211, 1'b0, 1'b0, -1, cap);
    n_total++;
    if (cap[7:0] !== 8'hD5) begin  // 1,0,1,0,1,0,1,1 in send order
      n_bad++;
      $display("FAIL sorted_preamble: got %h want d5", cap[7:0]);
    end
    n_total++;
    if (cap[15:8] !== 8'h11) begin
      n_bad++;
      $display("FAIL sorted_first_byte: got %h want 11", cap[15:8]);
    end
    n_total++;
    if (cap[39:8] !== 32'h44332211) begin
      n_bad++;
      $display("FAIL sorted_data: got %h want 44332211", cap[39:8]);
    end
    n_total++;
    if (cap[47:40] !== 8'hE4) begin
      n_bad++;
      $display("FAIL sorted_index: got %h want e4", cap[47:40]);
    end
  endtask

  task automatic test_reversed();
    logic [FB-1:0] cap;
    run_frame(32'h11223344, 1'b0, 1'b0, -1, cap);
    n_total++;
    if (cap[39:8] !== 32'h44332211) begin
      n_bad++;
      $display("FAIL reversed_data: got %h want 44332211", cap[39:8]);
    end
    n_total++;
    if (cap[47:40] !== 8'h1B) begin
      n_bad++;
      $display("FAIL reversed_index: got %h want 1b", cap[47:40]);
    end
    n_total++;
    if (cap !== model_frame(32'h11223344)) begin
      n_bad++;
      $display("FAIL reversed_frame: got %h want %h", cap, model_frame(32'h11223344));
    end
  endtask

  task automatic test_equal();
    logic [FB-1:0] cap;
    run_frame(32'h05050505, 1'b1, 1'b0, -1, cap);
    n_total++;
    if (cap[47:40] !== 8'hE4) begin
      n_bad++;
      $display("FAIL equal_index: got %h want e4", cap[47:40]);
    end
    n_total++;
    if (cap[39:8] !== 32'h05050505) begin
      n_bad++;
      $display("FAIL equal_data: got %h want 05050505", cap[39:8]);
    end
  endtask

  task automatic test_load_tick();
    logic [FB-1:0] cap;
    logic [PB-1:0] pkt;
    bit_tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if ({ready, tx_active, data_stream} !== 3'b100) begin
        n_bad++;
        $display("FAIL idle_tick %0d: got %b want 100", i, {ready, tx_active, data_stream});
      end
    end
    bit_tick = 1'b0;
    pkt = PB'($urandom);
    run_frame(pkt, 1'b0, 1'b1, 20, cap);
    n_total++;
    if (cap !== model_frame(pkt)) begin
      n_bad++;
      $display("FAIL junk_load_frame: got %h want %h", cap, model_frame(pkt));
    end
    pkt = PB'($urandom);
    run_frame(pkt, 1'b0, 1'b0, FB - 1, cap);
    n_total++;
    if (cap !== model_frame(pkt)) begin
      n_bad++;
      $display("FAIL final_tick_load_frame: got %h want %h", cap, model_frame(pkt));
    end
    repeat (2) @(negedge clk);
    n_total++;
    if ({ready, tx_active} !== 2'b10) begin
      n_bad++;
      $display("FAIL final_tick_load_ignored: ready,tx_active got %b want 10", {ready, tx_active});
    end
  endtask

  task automatic test_back_to_back();
    logic [FB-1:0] cap;
    logic [PB-1:0] pkt;
    for (int n = 0; n < 5; n++) begin
      pkt = PB'($urandom);
      run_frame(pkt, 1'b1, 1'b0, -1, cap);
      n_total++;
      if (cap !== model_frame(pkt)) begin
        n_bad++;
        $display("FAIL b2b_frame %0d: got %h want %h", n, cap, model_frame(pkt));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [FB-1:0] cap;
    logic [PB-1:0] pkt;
    int            c;
    sys_packet = PB'($urandom);
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
    c = 0;
    while ((tx_active !== 1'b1) && (c < 20)) begin
      @(negedge clk);
      c++;
    end
    bit_tick = 1'b1;
    repeat (20) @(negedge clk);
    bit_tick = 1'b0;
    reset_n  = 1'b0;
    #1;
    n_total++;
    if ({ready, tx_active, data_stream, done} !== 4'b1000) begin
      n_bad++;
      $display("FAIL mid_reset: got %b want 1000", {ready, tx_active, data_stream, done});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pkt = PB'($urandom);
    run_frame(pkt, 1'b0, 1'b0, -1, cap);
    n_total++;
    if (cap !== model_frame(pkt)) begin
      n_bad++;
      $display("FAIL post_reset_frame: got %h want %h", cap, model_frame(pkt));
    end
  endtask

  task automatic test_loopback();
    logic [FB-1:0] cap;
    logic [PB-1:0] pkt;
    for (int n = 0; n < 100; n++) begin
      // Half of the packets use a tiny byte alphabet to force duplicates.
      for (int k = 0; k < PACKET_WIDTH; k++)
        pkt[8*k +: 8] = (n % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      run_frame(pkt, (n % 5 == 0), 1'b0, -1, cap);
      n_total++;
      if (unsort(cap) !== pkt) begin
        n_bad++;
        $display("FAIL loopback %0d: got %h want %h", n, unsort(cap), pkt);
      end
      n_total++;
      if (cap !== model_frame(pkt)) begin
        n_bad++;
        $display("FAIL loopback_frame %0d: got %h want %h", n, cap, model_frame(pkt));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sorted();
    test_reversed();
    test_equal();
    test_load_tick();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
